// File: rtl/cpu_mc_sequencer_if.sv
// cpu_mc_sequencer_if: memory handshake, opcode and stage-enable bundle between the sequencer and the core
interface cpu_mc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             halt_req;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic             rf_we;
    logic             retired;
    logic [2:0]       stage;
    logic             halted;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;
    modport master (
        input  opcode, imem_ready, dmem_ready, halt_req,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retired,
               stage, halted, trap, trap_cause, instret
    );
    modport slave (
        output opcode, imem_ready, dmem_ready, halt_req,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retired,
               stage, halted, trap, trap_cause, instret
    );
endinterface

// File: rtl/cpu_mc_sequencer.sv
// cpu_mc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with traps and retire counter
module cpu_mc_sequencer #(
    parameter int MEM_TIMEOUT  = 15,
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_mc_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        RST, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, TRAP
    } state_t;
    localparam int WW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [4:0] C_LOAD   = 5'b00000;
    localparam logic [4:0] C_MISC   = 5'b00011;
    localparam logic [4:0] C_OPIMM  = 5'b00100;
    localparam logic [4:0] C_AUIPC  = 5'b00101;
    localparam logic [4:0] C_STORE  = 5'b01000;
    localparam logic [4:0] C_OP     = 5'b01100;
    localparam logic [4:0] C_LUI    = 5'b01101;
    localparam logic [4:0] C_BRANCH = 5'b11000;
    localparam logic [4:0] C_JALR   = 5'b11001;
    localparam logic [4:0] C_JAL    = 5'b11011;
    localparam logic [4:0] C_SYSTEM = 5'b11100;
    state_t           state, state_nx;
    logic [WW-1:0]    wcnt, wcnt_nx;
    logic [1:0]       cause, cause_nx;
    logic [CNT_W-1:0] instret;
    logic [4:0]       op_cls;
    logic             cls_ok;
    logic             op_legal, timeout;
    logic             is_load, is_store, is_sys, writes_rf;
    assign op_legal = (bus.opcode[1:0] == 2'b11) &&
                      (bus.opcode[6:2] inside {C_LOAD, C_MISC, C_OPIMM, C_AUIPC, C_STORE, C_OP,
                                               C_LUI, C_BRANCH, C_JALR, C_JAL, C_SYSTEM});
    // class is latched in DECODE so later stages never depend on the live opcode
    assign is_load   = cls_ok && (op_cls == C_LOAD);
    assign is_store  = cls_ok && (op_cls == C_STORE);
    assign is_sys    = cls_ok && (op_cls == C_SYSTEM);
    assign writes_rf = cls_ok && (op_cls inside {C_LOAD, C_OPIMM, C_AUIPC, C_OP, C_LUI, C_JAL, C_JALR});
    assign timeout   = (MEM_TIMEOUT != 0) && (int'(wcnt) == MEM_TIMEOUT - 1);
    always_comb begin
        state_nx = state;
        cause_nx = cause;
        case (state)
            RST:       state_nx = FETCH;
            FETCH: begin
                if (bus.imem_ready) state_nx = DECODE;
                else if (timeout) begin
                    state_nx = TRAP;
                    cause_nx = 2'b01;
                end
            end
            DECODE: begin
                if (op_legal) state_nx = EXECUTE;
                else if (ILLEGAL_TRAP) begin
                    state_nx = TRAP;
                    cause_nx = 2'b10;
                end else state_nx = WRITEBACK;
            end
            EXECUTE:   state_nx = (is_load || is_store) ? MEMORY : WRITEBACK;
            MEMORY: begin
                if (bus.dmem_ready) state_nx = WRITEBACK;
                else if (timeout) begin
                    state_nx = TRAP;
                    cause_nx = 2'b11;
                end
            end
            WRITEBACK: state_nx = (is_sys || bus.halt_req) ? HALT : FETCH;
            HALT:      state_nx = (!bus.halt_req && !is_sys) ? FETCH : HALT;
            default:   state_nx = state;
        endcase
    end
    assign wcnt_nx = (state_nx != state) ? '0 :
                     (state == FETCH || state == MEMORY) ? wcnt + 1'b1 : wcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST;
            wcnt    <= '0;
            cause   <= 2'b00;
            instret <= '0;
            op_cls  <= '0;
            cls_ok  <= 1'b0;
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            cause   <= cause_nx;
            instret <= (state == WRITEBACK) ? instret + 1'b1 : instret;
            op_cls  <= (state == DECODE) ? bus.opcode[6:2] : op_cls;
            cls_ok  <= (state == DECODE) ? op_legal : cls_ok;
        end
    end
    assign bus.imem_req   = (state == FETCH);
    assign bus.ir_we      = (state == FETCH) && bus.imem_ready;
    assign bus.dmem_req   = (state == MEMORY);
    assign bus.dmem_we    = (state == MEMORY) && is_store;
    assign bus.pc_we      = (state == WRITEBACK);
    assign bus.retired    = (state == WRITEBACK);
    assign bus.rf_we      = (state == WRITEBACK) && writes_rf;
    assign bus.stage      = state;
    assign bus.halted     = (state == HALT);
    assign bus.trap       = (state == TRAP);
    assign bus.trap_cause = cause;
    assign bus.instret    = instret;
endmodule

// File: tb/tb_cpu_mc_sequencer.sv
// tb_cpu_mc_sequencer: randomized instruction stream checked cycle by cycle against a per-instruction timeline model
module tb_cpu_mc_sequencer;
    localparam int TO = 15;
    localparam logic [8:0] C_IMR = 9'h100, C_DMR = 9'h080, C_DWE = 9'h040, C_IRW = 9'h020,
                           C_PCW = 9'h010, C_RFW = 9'h008, C_RET = 9'h004, C_HLT = 9'h002,
                           C_TRP = 9'h001, C_NONE = 9'h000;
    logic clk = 1'b0;
    logic rst1_n = 1'b0, rst0_n = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic ir = 1'b0, dr = 1'b0, hr = 1'b0;
    bit sel = 1'b0;
    int n_chk = 0, n_pass = 0;
    int unsigned m_instret = 0;
    logic [1:0] m_cause = 2'b00;
    int res;
    logic [6:0] legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [6:0] rf_ops [7]     = '{7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F};
    logic [6:0] bad_ops [4]    = '{7'h7F, 7'h10, 7'h0B, 7'h57};
    always #5 clk = ~clk;
    cpu_mc_sequencer_if #(.CNT_W(32)) b1();
    cpu_mc_sequencer_if #(.CNT_W(4))  b0();
    cpu_mc_sequencer #(.MEM_TIMEOUT(TO), .ILLEGAL_TRAP(1'b1), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
    cpu_mc_sequencer #(.MEM_TIMEOUT(TO), .ILLEGAL_TRAP(1'b0), .CNT_W(4))  dut0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
    assign b1.opcode = opcode;
    assign b1.imem_ready = ir;
    assign b1.dmem_ready = dr;
    assign b1.halt_req = hr;
    assign b0.opcode = opcode;
    assign b0.imem_ready = ir;
    assign b0.dmem_ready = dr;
    assign b0.halt_req = hr;
    logic [8:0] ctl1, ctl0;
    assign ctl1 = {b1.imem_req, b1.dmem_req, b1.dmem_we, b1.ir_we, b1.pc_we, b1.rf_we, b1.retired, b1.halted, b1.trap};
    assign ctl0 = {b0.imem_req, b0.dmem_req, b0.dmem_we, b0.ir_we, b0.pc_we, b0.rf_we, b0.retired, b0.halted, b0.trap};
    function automatic bit in_legal(input logic [6:0] op);
        bit f = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) f = 1'b1;
        return f;
    endfunction
    function automatic bit in_rf(input logic [6:0] op);
        bit f = 1'b0;
        foreach (rf_ops[i]) if (rf_ops[i] == op) f = 1'b1;
        return f;
    endfunction
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic check(input logic [2:0] est, input logic [8:0] ectl, input string tag);
        logic [2:0]  st = sel ? b0.stage : b1.stage;
        logic [8:0]  c  = sel ? ctl0 : ctl1;
        logic [1:0]  ca = sel ? b0.trap_cause : b1.trap_cause;
        logic [31:0] ic = sel ? 32'(b0.instret) : b1.instret;
        logic [31:0] ei = sel ? (m_instret & 32'hF) : m_instret;
        n_chk++;
        assert (st === est) n_pass++;
        else $error("FAIL %s stage obs=%0d exp=%0d", tag, st, est);
        n_chk++;
        assert (c === ectl) n_pass++;
        else $error("FAIL %s ctl obs=%b exp=%b", tag, c, ectl);
        n_chk++;
        assert (ca === m_cause) n_pass++;
        else $error("FAIL %s cause obs=%b exp=%b", tag, ca, m_cause);
        n_chk++;
        assert (ic === ei) n_pass++;
        else $error("FAIL %s instret obs=%0d exp=%0d", tag, ic, ei);
    endtask
    task automatic cyc(input logic i, input logic d, input logic h, input logic [2:0] est,
                       input logic [8:0] ectl, input string tag);
        @(negedge clk);
        ir = i;
        dr = d;
        hr = h;
        #1;
        check(est, ectl, tag);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst1_n = 1'b0;
        rst0_n = 1'b0;
        m_instret = 0;
        m_cause = 2'b00;
        #1;
        check(3'd0, C_NONE, "reset");
        @(negedge clk);
        if (sel) rst0_n = 1'b1;
        else rst1_n = 1'b1;
    endtask
    // res: 0 back to FETCH, 1 halted by request, 2 halted by SYSTEM, 3 trapped
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic h, output int r);
        bit lg = in_legal(op);
        bit ld = lg && op == 7'h03;
        bit stv = lg && op == 7'h23;
        bit sys = lg && op == 7'h73;
        bit wr = lg && in_rf(op);
        r = 0;
        opcode = op;
        for (int k = 0; k <= iw && k < TO; k++)
            cyc(k == iw, rb(), rb(), 3'd1, C_IMR | ((k == iw) ? C_IRW : C_NONE), "fetch");
        if (iw >= TO) begin
            m_cause = 2'b01;
            r = 3;
            return;
        end
        cyc(rb(), rb(), rb(), 3'd2, C_NONE, "decode");
        if (!lg && !sel) begin
            m_cause = 2'b10;
            r = 3;
            return;
        end
        if (lg) cyc(rb(), rb(), rb(), 3'd3, C_NONE, "execute");
        if (ld || stv) begin
            for (int k = 0; k <= dw && k < TO; k++)
                cyc(rb(), k == dw, rb(), 3'd4, C_DMR | (stv ? C_DWE : C_NONE), "memory");
            if (dw >= TO) begin
                m_cause = 2'b11;
                r = 3;
                return;
            end
        end
        cyc(rb(), rb(), h, 3'd5, C_PCW | C_RET | (wr ? C_RFW : C_NONE), "writeback");
        m_instret++;
        r = sys ? 2 : (h ? 1 : 0);
    endtask
    task automatic settle(input int r);
        if (r == 3) begin
            for (int k = 0; k < 3; k++) cyc(rb(), rb(), rb(), 3'd7, C_TRP, "trap");
            do_reset();
        end else if (r == 2) begin
            for (int k = 0; k < 3; k++) cyc(rb(), rb(), rb(), 3'd6, C_HLT, "halt_sys");
            do_reset();
        end else if (r == 1) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc(rb(), rb(), 1'b1, 3'd6, C_HLT, "halt_hold");
            cyc(rb(), rb(), 1'b0, 3'd6, C_HLT, "halt_rel");
        end
    endtask
    task automatic rand_instr(input bit allow_mem_fault);
        logic [6:0] op = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 3)] : legal_ops[$urandom_range(0, 10)];
        int iw = ($urandom_range(0, 15) == 0 && allow_mem_fault) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3));
        int dw = ($urandom_range(0, 15) == 0 && allow_mem_fault) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3));
        int r;
        run_instr(op, iw, dw, $urandom_range(0, 5) == 0, r);
        settle(r);
    endtask
    initial begin
        do_reset();
        run_instr(7'h13, 0, 0, 1'b0, res);
        run_instr(7'h03, 0, 3, 1'b0, res);
        run_instr(7'h23, 1, 0, 1'b0, res);
        run_instr(7'h63, 0, 0, 1'b0, res);
        run_instr(7'h13, 0, 0, 1'b1, res);
        settle(res);
        run_instr(7'h33, 14, 0, 1'b0, res);
        run_instr(7'h03, 0, 14, 1'b0, res);
        opcode = 7'h03;
        cyc(1'b1, 1'b0, 1'b0, 3'd1, C_IMR | C_IRW, "abort_fetch");
        cyc(1'b0, 1'b0, 1'b0, 3'd2, C_NONE, "abort_decode");
        cyc(1'b0, 1'b0, 1'b0, 3'd3, C_NONE, "abort_execute");
        cyc(1'b0, 1'b0, 1'b0, 3'd4, C_DMR, "abort_memory");
        do_reset();
        run_instr(7'h13, 20, 0, 1'b0, res);
        settle(res);
        run_instr(7'h7F, 0, 0, 1'b0, res);
        settle(res);
        run_instr(7'h23, 0, 15, 1'b0, res);
        settle(res);
        run_instr(7'h73, 0, 0, 1'b0, res);
        settle(res);
        for (int n = 0; n < 60; n++) rand_instr(1'b1);
        sel = 1'b1;
        do_reset();
        run_instr(7'h7F, 0, 0, 1'b0, res);
        settle(res);
        run_instr(7'h10, 2, 0, 1'b1, res);
        settle(res);
        for (int n = 0; n < 24; n++) rand_instr(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
